// File: rtl/rv3n_chain_step_ctrl.sv
// Issue-chain flow controller: occupancy tracking, chain_step
// generation, halt/drain sequencing and stall statistics.
module rv3n_chain_step_ctrl #(
   parameter int PNUM      = 4,
   parameter int CHAIN_LEN = 4,
   parameter int OCC_W     = $clog2(CHAIN_LEN + 1),
   parameter int STALL_W   = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               stage_clear,
   input  logic [PNUM-1:0]    id_valid,
   input  logic               id_halt,
   input  logic               chain_retire,
   input  logic               resume,
   output logic               chain_step,
   output logic [OCC_W-1:0]   occupancy,
   output logic [2:0]         ctrl_state,
   output logic [STALL_W-1:0] stall_count,
   output logic               retire_err
);

   localparam logic [2:0] S_RUN   = 3'b001;
   localparam logic [2:0] S_DRAIN = 3'b010;
   localparam logic [2:0] S_HALT  = 3'b100;

   localparam logic [OCC_W-1:0]   OCC_MAX   = OCC_W'(CHAIN_LEN);
   localparam logic [STALL_W-1:0] STALL_MAX = '1;

   logic [2:0]       state;
   logic [2:0]       state_nxt;
   logic [OCC_W-1:0] occ_nxt;
   logic             has_grp;
   logic             inc;
   logic             dec;
   logic             stall;

   assign has_grp = |id_valid;
   assign inc     = chain_step & has_grp;
   assign dec     = chain_retire & (occupancy != '0);
   assign stall   = has_grp & ~chain_step & ~stage_clear;

   // A flush empties the chain outright; otherwise inc/dec net out.
   always_comb begin
      occ_nxt = occupancy;
      if (stage_clear)
         occ_nxt = '0;
      else
         occ_nxt = occupancy + OCC_W'(inc) - OCC_W'(dec);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_RUN;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      if (stage_clear) begin
         state_nxt = S_RUN;
      end else begin
         unique case (1'b1)
            state[0]: if (inc & id_halt)     state_nxt = S_DRAIN;
            state[1]: if (occ_nxt == '0)     state_nxt = S_HALT;
            state[2]: if (resume)            state_nxt = S_RUN;
            default:                         state_nxt = S_RUN;
         endcase
      end
   end

   // A same-cycle retire frees the slot a full chain needs.
   always_comb begin
      ctrl_state = state;
      chain_step = 1'b0;
      if (!stage_clear && state == S_RUN)
         chain_step = (occupancy < OCC_MAX) | chain_retire;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         occupancy   <= '0;
         stall_count <= '0;
         retire_err  <= 1'b0;
      end else begin
         occupancy <= occ_nxt;
         if (stall && stall_count != STALL_MAX)
            stall_count <= stall_count + 1'b1;
         if (chain_retire && occupancy == '0)
            retire_err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_rv3n_chain_step_ctrl.sv
// Directed testbench for rv3n_chain_step_ctrl: fill, full-chain
// retire, halt/drain/resume, flush, underflow and stall saturation.
module tb_rv3n_chain_step_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        stage_clear;
   logic [3:0]  id_valid;
   logic        id_halt;
   logic        chain_retire;
   logic        resume;
   logic        chain_step;
   logic [2:0]  occupancy;
   logic [2:0]  ctrl_state;
   logic [15:0] stall_count;
   logic        retire_err;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   rv3n_chain_step_ctrl dut (
      .clk          (clk),
      .rst          (rst),
      .stage_clear  (stage_clear),
      .id_valid     (id_valid),
      .id_halt      (id_halt),
      .chain_retire (chain_retire),
      .resume       (resume),
      .chain_step   (chain_step),
      .occupancy    (occupancy),
      .ctrl_state   (ctrl_state),
      .stall_count  (stall_count),
      .retire_err   (retire_err)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      stage_clear  = 1'b0;
      id_valid     = 4'h0;
      id_halt      = 1'b0;
      chain_retire = 1'b0;
      resume       = 1'b0;
   endtask

   task automatic do_reset();
      idle_inputs();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      #1;
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if (ctrl_state !== 3'b001) begin
         errors++;
         $display("FAIL reset_state got %b want 001", ctrl_state);
      end
      checks++;
      if (occupancy !== 3'd0) begin
         errors++;
         $display("FAIL reset_occ got %0d want 0", occupancy);
      end
      checks++;
      if (stall_count !== 16'd0) begin
         errors++;
         $display("FAIL reset_stall got %0d want 0", stall_count);
      end
      checks++;
      if (retire_err !== 1'b0) begin
         errors++;
         $display("FAIL reset_err got %b want 0", retire_err);
      end
      checks++;
      if (chain_step !== 1'b1) begin
         errors++;
         $display("FAIL reset_step got %b want 1", chain_step);
      end
   endtask

   task automatic test_fill();
      do_reset();
      id_valid = 4'hF;
      for (int i = 0; i < 4; i++) begin
         #1;
         checks++;
         if (chain_step !== 1'b1) begin
            errors++;
            $display("FAIL fill_step[%0d] got %b want 1", i, chain_step);
         end
         tick();
         checks++;
         if (occupancy !== 3'(i + 1)) begin
            errors++;
            $display("FAIL fill_occ[%0d] got %0d want %0d",
                     i, occupancy, i + 1);
         end
      end
      for (int k = 0; k < 3; k++) begin
         checks++;
         if (chain_step !== 1'b0 || stall_count !== 16'(k)) begin
            errors++;
            $display("FAIL fill_stall[%0d] got step=%b cnt=%0d want 0/%0d",
                     k, chain_step, stall_count, k);
         end
         tick();
      end
      checks++;
      if (stall_count !== 16'd3) begin
         errors++;
         $display("FAIL fill_stall_end got %0d want 3", stall_count);
      end
   endtask

   task automatic test_full_retire();
      id_valid     = 4'h1;
      chain_retire = 1'b1;
      #1;
      checks++;
      if (chain_step !== 1'b1) begin
         errors++;
         $display("FAIL full_ret_step got %b want 1", chain_step);
      end
      tick();
      chain_retire = 1'b0;
      #1;
      checks++;
      if (occupancy !== 3'd4) begin
         errors++;
         $display("FAIL full_ret_occ got %0d want 4", occupancy);
      end
      checks++;
      if (chain_step !== 1'b0) begin
         errors++;
         $display("FAIL full_noret_step got %b want 0", chain_step);
      end
      checks++;
      if (stall_count !== 16'd3) begin
         errors++;
         $display("FAIL full_ret_stall got %0d want 3", stall_count);
      end
   endtask

   task automatic test_halt_drain();
      do_reset();
      id_halt = 1'b1;
      tick();
      checks++;
      if (ctrl_state !== 3'b001) begin
         errors++;
         $display("FAIL halt_novalid got %b want 001", ctrl_state);
      end
      id_halt  = 1'b0;
      id_valid = 4'hF;
      tick();
      tick();
      id_halt = 1'b1;
      #1;
      checks++;
      if (chain_step !== 1'b1) begin
         errors++;
         $display("FAIL halt_accept_step got %b want 1", chain_step);
      end
      tick();
      id_halt  = 1'b0;
      id_valid = 4'h0;
      checks++;
      if (occupancy !== 3'd3 || ctrl_state !== 3'b010) begin
         errors++;
         $display("FAIL halt_drain got occ=%0d st=%b want 3/010",
                  occupancy, ctrl_state);
      end
      chain_retire = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1;
         checks++;
         if (chain_step !== 1'b0) begin
            errors++;
            $display("FAIL drain_step[%0d] got %b want 0", i, chain_step);
         end
         tick();
         checks++;
         if (occupancy !== 3'(2 - i) ||
             ctrl_state !== ((i == 2) ? 3'b100 : 3'b010)) begin
            errors++;
            $display("FAIL drain_ret[%0d] got occ=%0d st=%b", i,
                     occupancy, ctrl_state);
         end
      end
      chain_retire = 1'b0;
      id_valid     = 4'hF;
      tick();
      checks++;
      if (chain_step !== 1'b0 || ctrl_state !== 3'b100) begin
         errors++;
         $display("FAIL halt_hold got step=%b st=%b want 0/100",
                  chain_step, ctrl_state);
      end
      resume = 1'b1;
      tick();
      resume = 1'b0;
      #1;
      checks++;
      if (ctrl_state !== 3'b001 || chain_step !== 1'b1) begin
         errors++;
         $display("FAIL resume got st=%b step=%b want 001/1",
                  ctrl_state, chain_step);
      end
   endtask

   task automatic test_clear();
      do_reset();
      id_valid = 4'hF;
      tick();
      tick();
      id_halt = 1'b1;
      tick();
      id_halt = 1'b0;
      tick();
      tick();
      stage_clear = 1'b1;
      resume      = 1'b1;
      #1;
      checks++;
      if (chain_step !== 1'b0) begin
         errors++;
         $display("FAIL clear_step got %b want 0", chain_step);
      end
      tick();
      stage_clear = 1'b0;
      resume      = 1'b0;
      id_valid    = 4'h0;
      checks++;
      if (ctrl_state !== 3'b001 || occupancy !== 3'd0 ||
          stall_count !== 16'd2) begin
         errors++;
         $display("FAIL clear_drain got st=%b occ=%0d cnt=%0d want 001/0/2",
                  ctrl_state, occupancy, stall_count);
      end
      id_valid = 4'h2;
      id_halt  = 1'b1;
      tick();
      id_valid = 4'h0;
      id_halt  = 1'b0;
      chain_retire = 1'b1;
      tick();
      chain_retire = 1'b0;
      checks++;
      if (ctrl_state !== 3'b100) begin
         errors++;
         $display("FAIL clear_pre_halt got %b want 100", ctrl_state);
      end
      stage_clear = 1'b1;
      resume      = 1'b1;
      tick();
      stage_clear = 1'b0;
      resume      = 1'b0;
      checks++;
      if (ctrl_state !== 3'b001 || occupancy !== 3'd0 ||
          stall_count !== 16'd2) begin
         errors++;
         $display("FAIL clear_halt got st=%b occ=%0d cnt=%0d want 001/0/2",
                  ctrl_state, occupancy, stall_count);
      end
   endtask

   task automatic test_underflow();
      do_reset();
      chain_retire = 1'b1;
      tick();
      chain_retire = 1'b0;
      checks++;
      if (occupancy !== 3'd0 || retire_err !== 1'b1) begin
         errors++;
         $display("FAIL underflow got occ=%0d err=%b want 0/1",
                  occupancy, retire_err);
      end
      stage_clear = 1'b1;
      tick();
      stage_clear = 1'b0;
      checks++;
      if (retire_err !== 1'b1) begin
         errors++;
         $display("FAIL underflow_sticky got %b want 1", retire_err);
      end
      do_reset();
      checks++;
      if (retire_err !== 1'b0) begin
         errors++;
         $display("FAIL underflow_rst got %b want 0", retire_err);
      end
   endtask

   task automatic test_saturate();
      do_reset();
      id_valid = 4'hF;
      for (int i = 0; i < 4; i++) tick();
      for (int i = 0; i < 65534; i++) tick();
      checks++;
      if (stall_count !== 16'hFFFE) begin
         errors++;
         $display("FAIL sat_pre got %h want fffe", stall_count);
      end
      tick();
      checks++;
      if (stall_count !== 16'hFFFF) begin
         errors++;
         $display("FAIL sat_max got %h want ffff", stall_count);
      end
      tick();
      tick();
      checks++;
      if (stall_count !== 16'hFFFF) begin
         errors++;
         $display("FAIL sat_hold got %h want ffff", stall_count);
      end
   endtask

   initial begin
      rst = 1'b1;
      idle_inputs();
      test_reset();
      test_fill();
      test_full_retire();
      test_halt_drain();
      test_clear();
      test_underflow();
      test_saturate();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
